pencere_uretici: RTL and testbench
==================================

PENCERE_URETICI -- requirements
Module: pencere_uretici

Interface
REQ-001 The block SHALL have parameter GENISLIK, default 320, meaning image width in pixels (>= 3).
REQ-002 The block SHALL have parameter YUKSEKLIK, default 240, meaning image height in lines (>= 3).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port etkin_i  input  1  input pixel valid; pixel accepted on every cycle it is high (no backpressure).
REQ-006 The block SHALL have port cerceve_basi_i  input  1  start of frame; qualified by etkin_i.
REQ-007 The block SHALL have port pixel_i  input  `PIXEL_BIT  raster-order input pixel.
REQ-008 The block SHALL have port etkin_o  output  1  one-cycle pulse, one per emitted 3x3 window.
REQ-009 The block SHALL have port resim_o  output  72  3x3 window, 9 bytes, consumer-compatible with the median block.
REQ-010 The block SHALL have port cerceve_bitti_o  output  1  end-of-frame pulse; present only with PENCERE_BITTI_EN.

Function
REQ-011 The block SHALL track column counter sutun (0..GENISLIK-1) and row counter satir (0..YUKSEKLIK-1) of the next accepted pixel.
REQ-012 Each accepted pixel SHALL advance sutun; at GENISLIK-1, sutun SHALL wrap to 0 and satir SHALL increment; at (YUKSEKLIK-1, GENISLIK-1), both SHALL wrap to 0.
REQ-013 When etkin_i and cerceve_basi_i are both high, the accepted pixel SHALL be treated as (0,0), overriding the counter values.
REQ-014 cerceve_basi_i without etkin_i SHALL be ignored.
REQ-015 The block SHALL hold two line buffers of GENISLIK bytes, storing rows satir-1 and satir-2, written/rotated on each accepted pixel.
REQ-016 The block SHALL hold a 3x3 shift window, which shifts one column on each accepted pixel only.
REQ-017 On accepting pixel (r,c) with r>=2 and c>=2, the block SHALL emit the window covering rows r-2..r and columns c-2..c.
REQ-018 The window SHALL be registered: etkin_o is high exactly 1 cycle after the accepting edge.
REQ-019 No window SHALL be emitted for r<2 or c<2, so there are exactly (GENISLIK-2)*(YUKSEKLIK-2) windows per frame.
REQ-020 Byte k of resim_o (bits 8k+7:8k) SHALL be the window pixel at row k/3, column k%3; byte 0 is top-left and byte 8 is the current pixel.
REQ-021 resim_o SHALL hold the last emitted window while etkin_o is low.
REQ-022 Input gaps (etkin_i low) SHALL not change window content or counters.

Reset
REQ-023 While rstn_i is low, the block SHALL drive etkin_o=0, resim_o=0, cerceve_bitti_o=0, sutun=0 and satir=0, asynchronously.
REQ-024 Line-buffer RAM SHALL need no reset; REQ-019 guarantees stale data is never emitted.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first pixel after release is (0,0).

Configuration
REQ-026 With PENCERE_BITTI_EN defined, cerceve_bitti_o SHALL pulse high in the same cycle as etkin_o for the window from pixel (YUKSEKLIK-1, GENISLIK-1).
REQ-027 Without PENCERE_BITTI_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (GENISLIK=4, YUKSEKLIK=4, pixel = 16*r + c)
REQ-028 Continuous frame, 16 pixels -> 4 etkin_o pulses; the first is 1 cycle after pixel 0x22 with resim_o=0x222120_121110_020100, and the last has byte0=0x11 and byte8=0x33.
REQ-029 Same frame with etkin_i toggling every other cycle -> identical 4 windows, each 1 cycle after its accepting pixel, with no extra pulses.
REQ-030 Two back-to-back frames (32 pixels) -> 8 windows; windows 5-8 equal windows 1-4.
REQ-031 cerceve_basi_i with the 7th pixel, then 16 pixels of a fresh frame -> no window before the new frame's pixel (2,2), then exactly 4 correct windows.
REQ-032 rstn_i low for 2 cycles after 10 pixels -> etkin_o stays 0, and a following full frame yields exactly 4 correct windows.
REQ-033 With PENCERE_BITTI_EN, one continuous frame -> cerceve_bitti_o exactly 1 pulse, coincident with the 4th etkin_o; without PENCERE_BITTI_EN, the port is absent and compilation is clean.

Source files
------------

// File: rtl/pencere_uretici.sv
// pencere_uretici -- 3x3 sliding-window generator for a raster pixel stream.
//
// Pixels arrive in raster order, one per cycle when etkin_i is high. Two line
// buffers hold the previous two rows, and a 3x3 shift register holds the last
// three columns. Once the accepted pixel sits at row >= 2 and column >= 2, the
// full 3x3 neighbourhood is emitted one cycle later.
//
// Stream protocol: the input is valid-only. A pixel is accepted on every rising
// edge where etkin_i is high, and there is no backpressure. The output is a
// one-cycle etkin_o pulse per window. resim_o holds its value between pulses.
//
// Parameters
//   GENISLIK   image width in pixels  (>= 3)
//   YUKSEKLIK  image height in lines  (>= 3)
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   rstn_i           asynchronous active-low reset
//   etkin_i          input pixel valid
//   cerceve_basi_i   start of frame, qualified by etkin_i; forces pixel to (0,0)
//   pixel_i          raster-order pixel, `PIXEL_BIT wide (default 8)
//   etkin_o          one-cycle pulse per emitted window
//   resim_o          window; byte k = row k/3, column k%3 (byte 0 top-left,
//                    byte 8 the current pixel)
//   cerceve_bitti_o  end-of-frame pulse, coincident with the window of the last
//                    pixel. Present only when PENCERE_BITTI_EN is defined.
//
// Optional feature macro: PENCERE_BITTI_EN

`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif

module pencere_uretici #(
  parameter int GENISLIK  = 320,
  parameter int YUKSEKLIK = 240
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    etkin_i,
  input  logic                    cerceve_basi_i,
  input  logic [`PIXEL_BIT-1:0]   pixel_i,
  output logic                    etkin_o,
  output logic [9*`PIXEL_BIT-1:0] resim_o
`ifdef PENCERE_BITTI_EN
  ,
  output logic                    cerceve_bitti_o
`endif
);

  localparam int PW = `PIXEL_BIT;
  localparam int SW = $clog2(GENISLIK);
  localparam int RW = $clog2(YUKSEKLIK);
  localparam logic [SW-1:0] SON_SUTUN = SW'(GENISLIK - 1);
  localparam logic [RW-1:0] SON_SATIR = RW'(YUKSEKLIK - 1);

  // Position of the next pixel to be accepted.
  logic [SW-1:0] sutun_q, sutun_d, cur_sutun;
  logic [RW-1:0] satir_q, satir_d, cur_satir;

  // lb1_q holds row satir-1 and lb2_q holds row satir-2, both indexed by column.
  logic [PW-1:0] lb1_q [GENISLIK];
  logic [PW-1:0] lb2_q [GENISLIK];

  // 3x3 window, row-major, index 0 = top-left.
  logic [PW-1:0] pen_q [9];
  logic [PW-1:0] pen_d [9];

  logic [PW-1:0]   ust, orta;
  logic [9*PW-1:0] resim_d;
  logic            pencere_var;

  always_comb begin
    // A start-of-frame pixel is (0,0), regardless of where the counters are.
    cur_sutun = cerceve_basi_i ? '0 : sutun_q;
    cur_satir = cerceve_basi_i ? '0 : satir_q;

    // Column above the incoming pixel: two rows up, and one row up.
    ust  = lb2_q[cur_sutun];
    orta = lb1_q[cur_sutun];

    // Shift the window left by one column. The new right column enters.
    for (int k = 0; k < 9; k++) pen_d[k] = pen_q[k];
    for (int i = 0; i < 3; i++) begin
      pen_d[3*i]     = pen_q[3*i+1];
      pen_d[3*i + 1] = pen_q[3*i+2];
    end
    pen_d[2] = ust;
    pen_d[5] = orta;
    pen_d[8] = pixel_i;

    resim_d = '0;
    for (int k = 0; k < 9; k++) resim_d[k*PW +: PW] = pen_d[k];

    if (cur_sutun == SON_SUTUN) begin
      sutun_d = '0;
      satir_d = (cur_satir == SON_SATIR) ? '0 : cur_satir + RW'(1);
    end else begin
      sutun_d = cur_sutun + SW'(1);
      satir_d = cur_satir;
    end

    // Only positions whose full 3x3 neighbourhood lies within the current
    // frame are emitted. Stale RAM contents therefore never reach the output.
    pencere_var = etkin_i && (cur_satir >= RW'(2)) && (cur_sutun >= SW'(2));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sutun_q <= '0;
      satir_q <= '0;
      etkin_o <= 1'b0;
      resim_o <= '0;
    end else begin
      etkin_o <= pencere_var;
      if (etkin_i) begin
        sutun_q <= sutun_d;
        satir_q <= satir_d;
      end
      if (pencere_var) resim_o <= resim_d;
    end
  end

  // Storage without reset: line buffers and the shift window.
  always_ff @(posedge clk_i) begin
    if (etkin_i) begin
      lb2_q[cur_sutun] <= orta;
      lb1_q[cur_sutun] <= pixel_i;
      for (int k = 0; k < 9; k++) pen_q[k] <= pen_d[k];
    end
  end

`ifdef PENCERE_BITTI_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cerceve_bitti_o <= 1'b0;
    end else begin
      cerceve_bitti_o <= pencere_var && (cur_satir == SON_SATIR) &&
                         (cur_sutun == SON_SUTUN);
    end
  end
`endif

endmodule

// File: tb/tb_pencere_uretici.sv
// Testbench for pencere_uretici with GENISLIK=4 and YUKSEKLIK=4.
//
// The bench keeps a 2-D image model of the current frame, so each expected
// window comes straight from the pixel positions. Every driven cycle pushes one
// expectation entry. The compare process pops one entry per falling edge and
// checks etkin_o, resim_o (or the held value) and, when enabled,
// cerceve_bitti_o. Literal checks pin the first and last windows and the pulse
// counts.
module tb_pencere_uretici;
  localparam int G  = 4;
  localparam int Y  = 4;
  localparam int EW = 74;  // {bitti, valid, window[71:0]}

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        etkin_i;
  logic        cerceve_basi_i;
  logic [7:0]  pixel_i;
  logic        etkin_o;
  logic [71:0] resim_o;
`ifdef PENCERE_BITTI_EN
  logic        cerceve_bitti_o;
`endif

  // Clock and reset wiring
  always #5 clk_i = ~clk_i;

  pencere_uretici #(.GENISLIK(G), .YUKSEKLIK(Y)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .etkin_i        (etkin_i),
    .cerceve_basi_i (cerceve_basi_i),
    .pixel_i        (pixel_i),
    .etkin_o        (etkin_o),
    .resim_o        (resim_o)
`ifdef PENCERE_BITTI_EN
    ,
    .cerceve_bitti_o(cerceve_bitti_o)
`endif
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            pulse_cnt = 0;
  int            bitti_cnt = 0;
  logic [71:0]   cap [16];
  logic [71:0]   last_win = '0;

  // Image model
  logic [7:0] img [Y][G];
  int         mr = 0;
  int         mc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: drive inputs for one cycle, update the model, and record the
  // expectation once the accepting edge has happened.
  task automatic drive(input logic v, input logic sof, input logic [7:0] px);
    logic [EW-1:0] e;
    etkin_i        = v;
    cerceve_basi_i = sof;
    pixel_i        = px;
    e = '0;
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        e[72] = 1'b1;
        for (int k = 0; k < 9; k++) e[8*k +: 8] = img[mr-2+k/3][mc-2+k%3];
        e[73] = (mr == Y-1 && mc == G-1);
      end
      mc++;
      if (mc == G) begin
        mc = 0;
        mr++;
        if (mr == Y) mr = 0;
      end
    end
    @(posedge clk_i);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic pix(input int r, input int c, input logic sof);
    drive(1'b1, sof, 8'(16*r + c));
  endtask

  task automatic idle(input logic sof);
    drive(1'b0, sof, 8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset(input int n);
    rstn_i         = 1'b0;
    etkin_i        = 1'b0;
    cerceve_basi_i = 1'b0;
    pixel_i        = '0;
    last_win       = '0;
    mr = 0;
    mc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      exp_q.push_back('0);
      #1;
    end
    rstn_i = 1'b1;
  endtask

  task automatic frame(input logic gaps);
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < G; c++) begin
        pix(r, c, 1'b0);
        if (gaps) idle(1'b1);  // start of frame without etkin_i must be ignored
      end
  endtask

  task automatic start_test();
    pulse_cnt = 0;
    bitti_cnt = 0;
  endtask

  task automatic end_test(input string name, input int pulses, input int bittis);
    idle(1'b0);
    idle(1'b0);
    check({name, "_pulses"}, pulse_cnt, pulses);
`ifdef PENCERE_BITTI_EN
    check({name, "_bitti"}, bitti_cnt, bittis);
`else
    if (bittis < 0) $display("unused");
`endif
  endtask

  // Compare process: one expectation per cycle, checked on the falling edge
  initial begin
    logic [EW-1:0] ce;
    forever begin
      @(negedge clk_i);
      if (etkin_o === 1'b1) begin
        if (pulse_cnt < 16) cap[pulse_cnt] = resim_o;
        pulse_cnt++;
      end
`ifdef PENCERE_BITTI_EN
      if (cerceve_bitti_o === 1'b1) bitti_cnt++;
`endif
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        check("etkin_o", etkin_o, ce[72]);
        if (ce[72]) begin
          check("resim_o", resim_o, ce[71:0]);
          last_win = ce[71:0];
        end else begin
          check("resim_hold", resim_o, last_win);
        end
`ifdef PENCERE_BITTI_EN
        check("cerceve_bitti_o", cerceve_bitti_o, ce[73]);
`endif
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Main sequence
  initial begin
    do_reset(3);

    // Test 1: continuous frame
    start_test();
    frame(1'b0);
    end_test("cont", 4, 1);
    check("first_win", cap[0], 72'h222120121110020100);
    check("last_b0", cap[3][7:0], 8'h11);
    check("last_b8", cap[3][71:64], 8'h33);

    // Test 2: gap after every pixel
    start_test();
    frame(1'b1);
    end_test("gaps", 4, 1);
    check("gap_first_win", cap[0], 72'h222120121110020100);
    check("gap_last_b8", cap[3][71:64], 8'h33);

    // Test 3: two back-to-back frames
    start_test();
    frame(1'b0);
    frame(1'b0);
    end_test("b2b", 8, 2);
    for (int i = 0; i < 4; i++) check("b2b_repeat", cap[4+i], cap[i]);

    // Test 4: start of frame with the 7th pixel restarts the frame
    start_test();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < G; c++) pix(r, c, (r == 0 && c == 0));
    end_test("sof", 4, 1);
    check("sof_first_win", cap[0], 72'h222120121110020100);

    // Test 5: reset mid-frame, then a full frame
    start_test();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i));
    do_reset(2);
    check("rst_no_pulse", pulse_cnt, 0);
    frame(1'b0);
    end_test("rst", 4, 1);
    check("rst_last_b0", cap[3][7:0], 8'h11);

    @(negedge clk_i);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
